text_console: RTL
=================

TEXT_CONSOLE -- requirements
Module: text_console

Interface
REQ-001 Parameter COLS, default 80, text columns per row.
REQ-002 Parameter ROWS, default 25, text rows per screen.
REQ-003 Parameter CURSOR_EN, default 1; 1 marks the cursor cell with bit 7 (invert) on the display read port.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  upstream byte present.
REQ-007 in_data  input  8  upstream byte (ASCII).
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 pos  input  11  display read address, row*COLS+col, from the VGA stage.
REQ-010 char  output  8  display character: bit 7 invert, bits 6:0 code.
REQ-011 cursor_pos  output  11  current cursor cell address.

Function
REQ-012 A byte SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-013 in_ready SHALL be 1 only in state IDLE.
REQ-014 FSM states SHALL be CLEAR, IDLE, SCROLL_COPY and SCROLL_FILL.
REQ-015 Printable bytes 0x20-0x7E SHALL write in_data[6:0] at cursor_pos and advance the cursor one column.
REQ-016 Writing at column COLS-1 SHALL wrap the cursor to column 0 of the next row.
REQ-017 0x0D SHALL set the column to 0, keeping the row.
REQ-018 0x0A SHALL advance the row and keep the column.
REQ-019 0x08 SHALL decrement the column if it is >0; at column 0 the cursor SHALL stay unchanged.
REQ-020 0x0C SHALL enter CLEAR and home the cursor to 0.
REQ-021 All other bytes SHALL be accepted and ignored.
REQ-022 A row advance from row ROWS-1 (via LF or wrap) SHALL leave the cursor on row ROWS-1 and enter SCROLL_COPY.
REQ-023 SCROLL_COPY SHALL copy cell a+COLS to cell a for a=0..(ROWS-1)*COLS-1, using a 1-cycle read-to-write pipeline.
REQ-024 SCROLL_FILL SHALL write 0x20 to the COLS cells of the last row and then return to IDLE.
REQ-025 A scroll SHALL hold in_ready=0 for exactly ROWS*COLS+1 cycles (2001 at defaults).
REQ-026 CLEAR SHALL write 0x20 to cells 0..ROWS*COLS-1, one per cycle, then enter IDLE.
REQ-027 CLEAR SHALL hold in_ready=0 for exactly ROWS*COLS cycles.
REQ-028 char SHALL be registered: char in cycle n+1 reflects pos in cycle n (1-cycle latency).
REQ-029 A write and a display read of the same cell in the same cycle SHALL return the old contents.
REQ-030 char[7] SHALL be 1 iff CURSOR_EN=1, state is IDLE and the registered pos equals cursor_pos.
REQ-031 A pos value >= ROWS*COLS SHALL return char=0x20 after one cycle.
REQ-032 cursor_pos SHALL equal row*COLS+col, 11-bit unsigned, and never exceed ROWS*COLS-1.

Reset
REQ-033 Asserting rst_n=0 SHALL force the CLEAR state, cursor_pos=0, in_ready=0, char=0x00 and the fill counter to 0, regardless of the current state.
REQ-034 After rst_n deasserts, a full CLEAR SHALL run before the first byte is accepted.
REQ-035 RAM contents SHALL NOT be reset directly; only the CLEAR pass initialises them.

Structure
REQ-036 COLS/ROWS defaults, the control codes (0x08, 0x0A, 0x0C, 0x0D), the blank code 0x20 and the FSM state encoding SHALL live in the shared package console_pkg.
REQ-037 Storage SHALL be one sub-module, text_ram: 2048x7, one write port and two registered read ports (display and scroll), inferable as block RAM.

Verification
REQ-038 Reset release -> in_ready stays 0 for 2000 cycles, then 1; reads of pos 0..1999 return 0x20 (0xA0 at pos 0 with cursor).
REQ-039 Send "AB" -> pos 0 reads 0x41, pos 1 reads 0x42; cursor_pos=2; pos 2 reads 0xA0.
REQ-040 Send 80 x 'x' -> cursor_pos=80; 0x0D then 0x08 -> cursor_pos=80 (no change).
REQ-041 Fill rows 0-24 with row index + 0x30, cursor at 1920, send 0x0A -> in_ready low 2001 cycles; row 0 reads 0x31, row 23 reads 0x48, row 24 reads 0x20; cursor_pos=1920.
REQ-042 Pulse rst_n low mid-scroll -> in_ready=0 and cursor_pos=0 immediately; full 2000-cycle CLEAR follows.
REQ-043 Send 0x0C after text -> 2000-cycle clear; all cells 0x20; cursor_pos=0.

Source files
------------

// File: rtl/console_pkg.sv
// console_pkg: shared geometry defaults, control codes and FSM encoding for the text console.
package console_pkg;
    localparam int COLS_DEFAULT = 80;
    localparam int ROWS_DEFAULT = 25;
    localparam int ADDR_W = 11;
    localparam logic [7:0] CODE_BS = 8'h08;
    localparam logic [7:0] CODE_LF = 8'h0A;
    localparam logic [7:0] CODE_FF = 8'h0C;
    localparam logic [7:0] CODE_CR = 8'h0D;
    localparam logic [7:0] CODE_BLANK = 8'h20;
    typedef enum logic [1:0] {CLEAR, IDLE, SCROLL_COPY, SCROLL_FILL} state_t;
    function automatic logic is_printable(input logic [7:0] b);
        return b >= 8'h20 && b <= 8'h7E;
    endfunction
endpackage

// File: rtl/text_ram.sv
// text_ram: 2048x7 character store, one write port and two registered read ports (display, scroll).
module text_ram
    import console_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [6:0]        wdata,
    input  logic [ADDR_W-1:0] daddr,
    output logic [6:0]        ddata,
    input  logic [ADDR_W-1:0] saddr,
    output logic [6:0]        sdata
);
    logic [6:0] mem [2**ADDR_W];
    // Reads sample pre-write contents, so a same-cell read returns old data.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        ddata <= mem[daddr];
        sdata <= mem[saddr];
    end
endmodule

// File: rtl/text_console.sv
// text_console: byte-stream text terminal with cursor, wrap, scroll and clear, plus a display read port.
module text_console
    import console_pkg::*;
#(
    parameter int COLS = COLS_DEFAULT,
    parameter int ROWS = ROWS_DEFAULT,
    parameter int CURSOR_EN = 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pos,
    output logic [7:0]        char,
    output logic [ADDR_W-1:0] cursor_pos
);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(ROWS * COLS - 1);
    localparam logic [ADDR_W-1:0] COPY_END  = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] COLS_L    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(ROWS - 1);

    state_t state, state_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx, row, row_nx, col, col_nx, waddr, pos_q;
    logic [6:0] wdata, ddata, sdata;
    logic we, adv, rd_ok, oob_q, inv;

    text_ram u_ram (
        .clk(clk), .we(we), .waddr(waddr), .wdata(wdata),
        .daddr(pos), .ddata(ddata), .saddr(cnt + COLS_L), .sdata(sdata)
    );

    assign in_ready = state == IDLE;
    assign cursor_pos = row * COLS_L + col;
    assign inv = CURSOR_EN != 0 && state == IDLE && pos_q == cursor_pos;
    assign char = !rd_ok ? 8'h00 : oob_q ? CODE_BLANK : {inv, ddata};

    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        row_nx = row;
        col_nx = col;
        adv = 1'b0;
        we = 1'b0;
        waddr = cursor_pos;
        wdata = CODE_BLANK[6:0];
        case (state)
            CLEAR: begin
                we = 1'b1;
                waddr = cnt;
                cnt_nx = cnt == LAST_CELL ? '0 : cnt + 1'b1;
                state_nx = cnt == LAST_CELL ? IDLE : CLEAR;
            end
            IDLE: if (in_valid) begin
                if (is_printable(in_data)) begin
                    we = 1'b1;
                    wdata = in_data[6:0];
                    adv = col == LAST_COL;
                    col_nx = adv ? '0 : col + 1'b1;
                end else if (in_data == CODE_CR) col_nx = '0;
                else if (in_data == CODE_LF) adv = 1'b1;
                else if (in_data == CODE_BS) col_nx = col != '0 ? col - 1'b1 : col;
                else if (in_data == CODE_FF) begin
                    state_nx = CLEAR;
                    row_nx = '0;
                    col_nx = '0;
                    cnt_nx = '0;
                end
                // A row advance off the bottom keeps the cursor on the last row and scrolls.
                if (adv && row == LAST_ROW) begin
                    state_nx = SCROLL_COPY;
                    cnt_nx = '0;
                end else if (adv) row_nx = row + 1'b1;
            end
            SCROLL_COPY: begin
                we = cnt != '0;
                waddr = cnt - 1'b1;
                wdata = sdata;
                cnt_nx = cnt == COPY_END ? '0 : cnt + 1'b1;
                state_nx = cnt == COPY_END ? SCROLL_FILL : SCROLL_COPY;
            end
            SCROLL_FILL: begin
                we = 1'b1;
                waddr = COPY_END + cnt;
                cnt_nx = cnt == LAST_COL ? '0 : cnt + 1'b1;
                state_nx = cnt == LAST_COL ? IDLE : SCROLL_FILL;
            end
            default: state_nx = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt <= '0;
            row <= '0;
            col <= '0;
            pos_q <= '0;
            oob_q <= 1'b0;
            rd_ok <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            row <= row_nx;
            col <= col_nx;
            pos_q <= pos;
            oob_q <= pos > LAST_CELL;
            rd_ok <= 1'b1;
        end
    end
endmodule
